led_pattern_sequencer: RTL
==========================

# led_pattern_sequencer

Avalon-MM slave that drives the 8-bit board LED bank with CPU-configured, self-timed patterns: static, blink, rotate, and a single-LED bounce. It replaces direct CPU bit-banging of the LED output port. Software writes mode, seed pattern and step period once, and the block sequences the LEDs autonomously on the system clock. It sits on the Qsys interconnect beside the other PIO peripherals and feeds the top-level LED pins.

## Interface
- No parameters. Widths are fixed: 8 LEDs, 24-bit period, 32-bit data bus.
- clk  in  1  system clock; all state is updated on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register select, word-addressed.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe. A write occurs when chipselect=1 and write_n=0.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address. Zero wait states, read latency 0.
- out_port  out  8  LED drive, registered.

## Operation
- Registers (unused bits read 0):
  - 0 CTRL: [0] enable, [2:1] mode (0 static, 1 blink, 2 rotate-left, 3 bounce).
  - 1 PATTERN: [7:0] seed pattern.
  - 2 PERIOD: [23:0] clocks per step. A value of 0 is treated as 1.
  - 3 STATUS (read): [7:0] current out_port, [8] running (enable and mode≠0), [23:16] step count. A write to address 3 clears the step count; its data is ignored.
- Restart: any write to CTRL or PATTERN performs a restart.
  - Prescaler ← 0.
  - Work register ← new PATTERN value.
  - Blink phase ← on.
  - Bounce position ← 0, direction ← up.
- out_port, by state:
  - enable=0: 8'h00. Prescaler is held at 0.
  - mode 0: PATTERN. No steps occur.
  - mode 1: PATTERN while phase is on, 8'h00 while phase is off. Phase toggles every step.
  - mode 2: work register, rotated left by 1 every step (bit7 → bit0).
  - mode 3: 1<<pos. pos runs 0→7 then 7→0, and direction flips on reaching 7 or 0. One full sweep takes 14 steps. PATTERN is ignored.
- Step (tick): running and prescaler ≥ P−1, where P = max(PERIOD,1). On a tick, prescaler ← 0, the pattern advances, and step count increments by 1 (8-bit, wraps 255→0). Otherwise, while running, the prescaler increments.
- PERIOD write: does not restart. Compare uses ≥, so lowering PERIOD below the current prescaler value forces a tick on the next edge.
- Simultaneous events:
  - Restart on the same edge as a tick: restart wins. No advance, no count.
  - STATUS clear on the same edge as a tick: count ← 0.
- Writes to addresses outside 0–3 cannot occur (2-bit address). Reads of address 3 are side-effect free.

## Timing
- Reset (asynchronous, takes effect immediately):
  - CTRL, PATTERN, PERIOD, prescaler, step count, pos ← 0.
  - phase ← on, direction ← up.
  - out_port = 8'h00.
- A register write on edge k is visible on readdata and out_port after edge k. out_port is a registered function of state.
- After a restart on edge k, the first tick is at edge k+P and subsequent ticks every P edges. With P=1, the pattern advances on every edge.
- reset_n deasserted mid-sequence: all state returns to reset values at once. The sequence does not resume.

## Test plan
- Reset, then read all four addresses → readdata = 0 each. out_port = 8'h00.
- Write PERIOD=4, PATTERN=8'h81, CTRL=0x5 (enable, rotate) at edge k → out_port = 81 after k. It is 03 after k+4 and 06 after k+8. STATUS[23:16] = 2 after k+8.
- Write PERIOD=0, CTRL=0x7 (bounce) → out_port = 01, 02, … 80, 40, … 01 on consecutive edges. The sweep repeats with period 14.
- Blink with PERIOD=3, PATTERN=8'hAA → out_port AA for 3 cycles, 00 for 3 cycles, repeating. A PATTERN write on a tick edge gives AA, with no toggle and no count.
- Rotate with PERIOD=1000, wait 500 cycles, write PERIOD=10 → tick on the next edge, then every 10 cycles.
- Run 256 steps → count wraps to 0. Write to address 3 on a tick edge → count = 0. Assert reset_n mid-run → out_port = 00 immediately.

Source files
------------

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: Avalon-MM slave sequencing an 8-LED bank through static, blink, rotate and bounce patterns.
module led_pattern_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  out_port
);
  logic [2:0]  ctrl_q, ctrl_d;
  logic [7:0]  pattern_q, pattern_d, work_q, work_d, count_q, count_d, out_q, out_d;
  logic [23:0] period_q, period_d, presc_q, presc_d, p_m1;
  logic [2:0]  pos_q, pos_d, pos_n;
  logic        phase_q, phase_d, dir_q, dir_d;
  logic        wr, restart, running, tick, wd_unused;
  assign wd_unused = &{1'b0, writedata[31:24]};
  assign wr = chipselect & ~write_n;
  assign restart = wr & ~address[1];
  assign running = ctrl_q[0] & (ctrl_q[2:1] != 2'd0);
  assign p_m1 = (period_q == 24'd0) ? 24'd0 : period_q - 24'd1;
  assign tick = running & (presc_q >= p_m1);
  // dir_q set means the bounce is travelling down toward bit 0
  assign pos_n = dir_q ? pos_q - 3'd1 : pos_q + 3'd1;
  always_comb begin
    ctrl_d = (wr && address == 2'd0) ? writedata[2:0] : ctrl_q;
    pattern_d = (wr && address == 2'd1) ? writedata[7:0] : pattern_q;
    period_d = (wr && address == 2'd2) ? writedata[23:0] : period_q;
    presc_d = (!ctrl_q[0] || restart || tick) ? 24'd0 : running ? presc_q + 24'd1 : presc_q;
    work_d = restart ? pattern_d : (tick && ctrl_q[2:1] == 2'd2) ? {work_q[6:0], work_q[7]} : work_q;
    phase_d = restart ? 1'b1 : (tick && ctrl_q[2:1] == 2'd1) ? ~phase_q : phase_q;
    pos_d = restart ? 3'd0 : (tick && ctrl_q[2:1] == 2'd3) ? pos_n : pos_q;
    dir_d = restart ? 1'b0 : (tick && ctrl_q[2:1] == 2'd3 && (pos_n == 3'd7 || pos_n == 3'd0)) ? ~dir_q : dir_q;
    count_d = (wr && address == 2'd3) ? 8'd0 : (tick && !restart) ? count_q + 8'd1 : count_q;
    // LEDs follow the post-edge state so writes show on out_port right after their edge
    out_d = !ctrl_d[0] ? 8'h00 :
            ctrl_d[2:1] == 2'd0 ? pattern_d :
            ctrl_d[2:1] == 2'd1 ? (phase_d ? pattern_d : 8'h00) :
            ctrl_d[2:1] == 2'd2 ? work_d : 8'd1 << pos_d;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= '0;
      pattern_q <= '0;
      period_q <= '0;
      presc_q <= '0;
      work_q <= '0;
      phase_q <= 1'b1;
      pos_q <= '0;
      dir_q <= 1'b0;
      count_q <= '0;
      out_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      pattern_q <= pattern_d;
      period_q <= period_d;
      presc_q <= presc_d;
      work_q <= work_d;
      phase_q <= phase_d;
      pos_q <= pos_d;
      dir_q <= dir_d;
      count_q <= count_d;
      out_q <= out_d;
    end
  end
  assign readdata = address == 2'd0 ? {29'd0, ctrl_q} :
                    address == 2'd1 ? {24'd0, pattern_q} :
                    address == 2'd2 ? {8'd0, period_q} :
                    {8'd0, count_q, 7'd0, running, out_q};
  assign out_port = out_q;
endmodule
